// File: rtl/vga_scroll_pattern_gen.sv
// vga_scroll_pattern_gen
//  Pipelined VGA test-pattern engine: bars, checker, gradient and solid white,
//  with per-frame horizontal scroll and a frame counter. Colour and syncs both
//  leave the block two clocks after hpos/vpos/display_on/syncs enter it.
//  Optional feature macro: PAT_VSCROLL_EN adds a vertical scroll offset that
//  advances downward by 'speed' on every unpaused frame edge.
module vga_scroll_pattern_gen #(
  parameter int COORD_W   = 10,
  parameter int CH_W      = 2,
  parameter int TILE_LOG2 = 5,
  parameter int FRAME_W   = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] hpos,
  input  logic [COORD_W-1:0] vpos,
  input  logic               display_on,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic [1:0]         mode,
  input  logic [3:0]         speed,
  input  logic               dir,
  input  logic               pause,
  output logic [CH_W-1:0]    r,
  output logic [CH_W-1:0]    g,
  output logic [CH_W-1:0]    b,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic [FRAME_W-1:0] frame_no
);

  localparam int T = TILE_LOG2;

  logic [COORD_W-1:0] h_off;
  logic [1:0]         mode_q;
  logic               prev_vsync;
  logic               vs_edge;
  logic [COORD_W-1:0] speed_ext;
  logic [COORD_W-1:0] sy_next;

  // Stage-1 registers
  logic [COORD_W-1:0] sx_q;
  logic [COORD_W-1:0] sy_q;
  logic               de_q;
  logic               hs_q;
  logic               vs_q;

  // Stage-2 combinational colour
  logic [CH_W-1:0]    r_next;
  logic [CH_W-1:0]    g_next;
  logic [CH_W-1:0]    b_next;

  // Frame edge is detected in the pixel clock domain; prev_vsync resets high
  // so a vsync already asserted at reset release is not counted as a frame.
  assign vs_edge   = vsync_in & ~prev_vsync;
  assign speed_ext = COORD_W'(speed);

  // Per-frame state: frame counter, latched mode and horizontal scroll offset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_vsync <= 1'b1;
      frame_no   <= '0;
      h_off      <= '0;
      mode_q     <= 2'd0;
    end else begin
      prev_vsync <= vsync_in;
      if (vs_edge) begin
        frame_no <= frame_no + FRAME_W'(1);
        mode_q   <= mode;
        if (!pause) begin
          h_off <= dir ? (h_off - speed_ext) : (h_off + speed_ext);
        end
      end
    end
  end

`ifdef PAT_VSCROLL_EN
  logic [COORD_W-1:0] v_off;

  // Vertical offset always moves downward, regardless of dir.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_off <= '0;
    end else if (vs_edge && !pause) begin
      v_off <= v_off + speed_ext;
    end
  end

  assign sy_next = vpos + v_off;
`else
  assign sy_next = vpos;
`endif

  // Stage 1: apply scroll offsets and delay the qualifiers alongside.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sx_q <= '0;
      sy_q <= '0;
      de_q <= 1'b0;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
    end else begin
      sx_q <= hpos + h_off;
      sy_q <= sy_next;
      de_q <= display_on;
      hs_q <= hsync_in;
      vs_q <= vsync_in;
    end
  end

  // Pattern selection from the stage-1 coordinates; blanked outside display.
  always_comb begin
    r_next = '0;
    g_next = '0;
    b_next = '0;
    if (de_q) begin
      case (mode_q)
        2'd0: begin
          r_next = {CH_W{sx_q[T]}};
          g_next = {CH_W{sx_q[T+1]}};
          b_next = {CH_W{sx_q[T+2]}};
        end
        2'd1: begin
          r_next = {CH_W{sx_q[T] ^ sy_q[T]}};
          g_next = {CH_W{sx_q[T] ^ sy_q[T]}};
          b_next = {CH_W{sx_q[T] ^ sy_q[T]}};
        end
        2'd2: begin
          r_next = sx_q[T +: CH_W];
          g_next = sy_q[T +: CH_W];
          b_next = sx_q[T +: CH_W] ^ sy_q[T +: CH_W];
        end
        default: begin
          r_next = '1;
          g_next = '1;
          b_next = '1;
        end
      endcase
    end
  end

  // Stage 2: register colour and syncs so they leave together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r         <= '0;
      g         <= '0;
      b         <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      r         <= r_next;
      g         <= g_next;
      b         <= b_next;
      hsync_out <= hs_q;
      vsync_out <= vs_q;
    end
  end

  // Only a few coordinate bits select the pattern; the rest are intentionally dropped.
  logic unused_coord_bits;
  assign unused_coord_bits = ^{sx_q, sy_q};

endmodule

// File: tb/tb_vga_scroll_pattern_gen.sv
// Directed testbench for vga_scroll_pattern_gen with hand-computed expectations
// (default parameters: COORD_W=10, CH_W=2, TILE_LOG2=5, FRAME_W=9).
module tb_vga_scroll_pattern_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       display_on;
  logic       hsync_in;
  logic       vsync_in;
  logic [1:0] mode;
  logic [3:0] speed;
  logic       dir;
  logic       pause;
  logic [1:0] r;
  logic [1:0] g;
  logic [1:0] b;
  logic       hsync_out;
  logic       vsync_out;
  logic [8:0] frame_no;

  int checks    = 0;
  int errors    = 0;
  int exp_frame = 0;

  vga_scroll_pattern_gen dut (
    .clk        (clk),
    .reset      (reset),
    .hpos       (hpos),
    .vpos       (vpos),
    .display_on (display_on),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .mode       (mode),
    .speed      (speed),
    .dir        (dir),
    .pause      (pause),
    .r          (r),
    .g          (g),
    .b          (b),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .frame_no   (frame_no)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rgb(input string tag, input logic [1:0] er, input logic [1:0] eg,
                           input logic [1:0] eb);
    check({tag, ".r"}, 16'(r), 16'(er));
    check({tag, ".g"}, 16'(g), 16'(eg));
    check({tag, ".b"}, 16'(b), 16'(eb));
  endtask

  // Present a pixel and wait out the two-cycle pipeline.
  task automatic pix(input logic [9:0] hp, input logic [9:0] vp, input logic de);
    hpos       = hp;
    vpos       = vp;
    display_on = de;
    tick();
    tick();
  endtask

  // One vsync pulse -> exactly one frame edge.
  task automatic pulse();
    vsync_in = 1'b1;
    tick();
    vsync_in = 1'b0;
    tick();
    exp_frame = (exp_frame + 1) % 512;
  endtask

  initial begin
    reset      = 1'b1;
    hpos       = 10'd32;
    vpos       = 10'd0;
    display_on = 1'b1;
    hsync_in   = 1'b1;
    vsync_in   = 1'b1;
    mode       = 2'd0;
    speed      = 4'd0;
    dir        = 1'b0;
    pause      = 1'b0;

    // 1: reset held mid-frame, then released with vsync already high
    tick(); tick(); tick();
    check_rgb("rst_hold", 2'd0, 2'd0, 2'd0);
    check("rst_hsync", 16'(hsync_out), 16'd0);
    check("rst_vsync", 16'(vsync_out), 16'd0);
    check("rst_frame", 16'(frame_no), 16'd0);
    reset      = 1'b0;
    hsync_in   = 1'b0;
    display_on = 1'b0;
    tick(); tick(); tick();
    check("no_spurious_edge", 16'(frame_no), 16'd0);
    vsync_in = 1'b0;
    tick();

    // 2: defaults, bars without scroll
    pix(10'd32, 10'd0, 1'b1);
    check_rgb("bars_32", 2'd3, 2'd0, 2'd0);
    pix(10'd64, 10'd0, 1'b1);
    check_rgb("bars_64", 2'd0, 2'd3, 2'd0);
    pix(10'd128, 10'd0, 1'b1);
    check_rgb("bars_128", 2'd0, 2'd0, 2'd3);
    pix(10'd32, 10'd0, 1'b0);
    check_rgb("blank", 2'd0, 2'd0, 2'd0);

    // sync delay is exactly two clocks
    hsync_in = 1'b1;
    tick();
    check("hsync_d1", 16'(hsync_out), 16'd0);
    tick();
    check("hsync_d2", 16'(hsync_out), 16'd1);
    hsync_in = 1'b0;
    tick(); tick();
    check("hsync_low", 16'(hsync_out), 16'd0);

    pulse();
    check("vsync_d2", 16'(vsync_out), 16'd1);
    tick();
    check("vsync_low", 16'(vsync_out), 16'd0);
    check("frame_1", 16'(frame_no), 16'd1);
    pix(10'd32, 10'd0, 1'b1);
    check_rgb("speed0_noscroll", 2'd3, 2'd0, 2'd0);

    // 3: scroll right by 3 per frame for 4 frames -> h_off = 12
    speed = 4'd3;
    dir   = 1'b0;
    pulse(); pulse(); pulse(); pulse();
    check("frame_5", 16'(frame_no), 16'd5);
    pix(10'd20, 10'd0, 1'b1);
    check_rgb("hoff12_h20", 2'd3, 2'd0, 2'd0);
    pix(10'd19, 10'd0, 1'b1);
    check_rgb("hoff12_h19", 2'd0, 2'd0, 2'd0);
    // dir=1, speed 10 -> h_off = 2
    speed = 4'd10;
    dir   = 1'b1;
    pulse();
    pix(10'd30, 10'd0, 1'b1);
    check_rgb("hoff2_h30", 2'd3, 2'd0, 2'd0);
    // dir=1, speed 3 from 2 -> h_off = 1023
    speed = 4'd3;
    pulse();
    pix(10'd0, 10'd0, 1'b1);
    check_rgb("hoff1023_h0", 2'd3, 2'd3, 2'd3);
    pix(10'd33, 10'd0, 1'b1);
    check_rgb("hoff1023_h33", 2'd3, 2'd0, 2'd0);
    pix(10'd1, 10'd0, 1'b1);
    check_rgb("hoff1023_h1", 2'd0, 2'd0, 2'd0);

    // 4: pause holds the offset while frames keep counting
    pause = 1'b1;
    dir   = 1'b0;
    pulse(); pulse();
    check("frame_9_paused", 16'(frame_no), 16'd9);
    pix(10'd0, 10'd0, 1'b1);
    check_rgb("paused_h0", 2'd3, 2'd3, 2'd3);
    pause = 1'b0;
    speed = 4'd0;
    pulse();
    pix(10'd0, 10'd0, 1'b1);
    check_rgb("speed0_h0", 2'd3, 2'd3, 2'd3);
    pause = 1'b1;
    while (exp_frame != 511) pulse();
    check("frame_511", 16'(frame_no), 16'd511);
    pulse();
    check("frame_wrap", 16'(frame_no), 16'd0);

    // 5: asynchronous reset, then mode change applied only at frame boundary
    #2 reset = 1'b1;
    #1;
    check("async_rst_frame", 16'(frame_no), 16'd0);
    tick();
    reset     = 1'b0;
    exp_frame = 0;
    mode      = 2'd1;
    pix(10'd32, 10'd0, 1'b1);
    check_rgb("mode_pending", 2'd3, 2'd0, 2'd0);
    pulse();
    check("frame_after_rst", 16'(frame_no), 16'd1);
    pix(10'd32, 10'd0, 1'b1);
    check_rgb("checker_32_0", 2'd3, 2'd3, 2'd3);
    pix(10'd32, 10'd32, 1'b1);
    check_rgb("checker_32_32", 2'd0, 2'd0, 2'd0);
    pix(10'd0, 10'd32, 1'b1);
    check_rgb("checker_0_32", 2'd3, 2'd3, 2'd3);
    mode = 2'd2;
    pulse();
    pix(10'd96, 10'd64, 1'b1);
    check_rgb("gradient", 2'd3, 2'd2, 2'd1);
    mode = 2'd3;
    pulse();
    pix(10'd5, 10'd7, 1'b1);
    check_rgb("solid", 2'd3, 2'd3, 2'd3);
    pix(10'd5, 10'd7, 1'b0);
    check_rgb("solid_blank", 2'd0, 2'd0, 2'd0);

    // 6: vertical scroll (only present when the feature macro is defined)
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pause = 1'b0;
    mode  = 2'd1;
    speed = 4'd2;
    dir   = 1'b0;
    pulse(); pulse(); pulse();
    pix(10'd0, 10'd26, 1'b1);
`ifdef PAT_VSCROLL_EN
    check_rgb("vscroll_v26", 2'd3, 2'd3, 2'd3);
`else
    check_rgb("vscroll_v26", 2'd0, 2'd0, 2'd0);
`endif
    dir = 1'b1;
    pulse();
    pix(10'd0, 10'd24, 1'b1);
`ifdef PAT_VSCROLL_EN
    check_rgb("vscroll_dir1_v24", 2'd3, 2'd3, 2'd3);
`else
    check_rgb("vscroll_dir1_v24", 2'd0, 2'd0, 2'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
